ctrl_pipeline: RTL and testbench

- Parametrised successor to the combinational LC-3b control ROM.
- Decodes the full LC-3b opcode set into a control word.
- Carries that word through registered EX/MEM/WB stages with valid bits, stall, flush and load-use interlock.
- Sequences two-access LDI/STI in the MEM stage with an FSM on the data-memory handshake.
- Sits between fetch/ID and the datapath; the datapath consumes ex_ctrl, mem_ctrl and wb_ctrl.

---
 rtl/ctrl_pipeline.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_ctrl_pipeline.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline.sv
// LC-3b control decode carried through EX/MEM/WB with stall, flush, load-use and LDI/STI sequencing.
// Optional saturating performance counters are built when CTRL_PERF_CNT_EN is defined.
module ctrl_pipeline #(
  parameter int INSTR_W        = 16,
  parameter int REG_IDX_W      = 3,
  parameter int LOAD_USE_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [INSTR_W-1:0] id_ir,
  output logic        id_ready,
  input  logic        flush,
  input  logic        mem_resp,
  output logic [16:0] ex_ctrl,
  output logic [16:0] mem_ctrl,
  output logic [16:0] wb_ctrl,
  output logic        ex_valid,
  output logic        mem_valid,
  output logic        wb_valid,
  output logic        mem_indirect_phase,
  output logic        illegal,
  output logic [15:0] perf_stall,
  output logic [15:0] perf_bubble,
  output logic [15:0] perf_flush
);

  localparam int CW = 17;

  localparam int B_STM   = 0;
  localparam int B_AMUX  = 1;
  localparam int B_ALUOP = 3;
  localparam int B_MRD   = 6;
  localparam int B_MWR   = 7;
  localparam int B_MBYTE = 8;
  localparam int B_MIND  = 9;
  localparam int B_RSEL  = 10;
  localparam int B_CC    = 11;
  localparam int B_DMUX  = 12;
  localparam int B_LDREG = 13;
  localparam int B_BR    = 14;
  localparam int B_JMP   = 15;
  localparam int B_PC2R  = 16;

  localparam logic [2:0] AL_ADD  = 3'd0;
  localparam logic [2:0] AL_AND  = 3'd1;
  localparam logic [2:0] AL_NOT  = 3'd2;
  localparam logic [2:0] AL_PASS = 3'd3;
  localparam logic [2:0] AL_SLL  = 3'd4;
  localparam logic [2:0] AL_SRL  = 3'd5;
  localparam logic [2:0] AL_SRA  = 3'd6;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_STB  = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_SHF  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  typedef enum logic [1:0] {
    M_IDLE,
    M_IND,
    M_FINAL
  } mstate_t;

  logic [3:0] op;
  logic [REG_IDX_W-1:0] id_dr, id_sr1, id_sr2;
  logic unused_ir;

  assign op        = id_ir[INSTR_W-1 -: 4];
  assign id_dr     = id_ir[9 +: REG_IDX_W];
  assign id_sr1    = id_ir[6 +: REG_IDX_W];
  assign id_sr2    = id_ir[0 +: REG_IDX_W];
  assign unused_ir = ^id_ir;

  logic [CW-1:0] dec_ctrl;
  logic dec_rti, use_sr1, use_sr2, use_sd;

  logic [CW-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [CW-1:0] mem_ctrl_q, wb_ctrl_q;
  logic [REG_IDX_W-1:0] ex_dest_q, ex_dest_d;
  logic ex_valid_q, ex_valid_d;
  logic mem_valid_q, wb_valid_q;
  logic illegal_q, illegal_d;
  mstate_t mst_q;
  logic phase_q;

  logic src_hit, load_use, take;
  logic mem_op, mem_final, mem_busy;

  // Opcode decode into a control word plus the register sources it reads
  always_comb begin
    dec_ctrl = '0;
    dec_rti  = 1'b0;
    use_sr1  = 1'b0;
    use_sr2  = 1'b0;
    use_sd   = 1'b0;
    unique case (op)
      OP_ADD, OP_AND, OP_NOT: begin
        if (op == OP_ADD) dec_ctrl[B_ALUOP +: 3] = AL_ADD;
        else if (op == OP_AND) dec_ctrl[B_ALUOP +: 3] = AL_AND;
        else dec_ctrl[B_ALUOP +: 3] = AL_NOT;
        if (id_ir[5]) dec_ctrl[B_AMUX +: 2] = 2'b10;
        dec_ctrl[B_CC]    = 1'b1;
        dec_ctrl[B_LDREG] = 1'b1;
        use_sr1 = 1'b1;
        use_sr2 = (op != OP_NOT) && !id_ir[5];
      end
      OP_SHF: begin
        unique case (id_ir[5:4])
          2'b01:   dec_ctrl[B_ALUOP +: 3] = AL_SRL;
          2'b11:   dec_ctrl[B_ALUOP +: 3] = AL_SRA;
          default: dec_ctrl[B_ALUOP +: 3] = AL_SLL;
        endcase
        dec_ctrl[B_AMUX +: 2] = 2'b11;
        dec_ctrl[B_CC]    = 1'b1;
        dec_ctrl[B_LDREG] = 1'b1;
        use_sr1 = 1'b1;
      end
      OP_LDR, OP_LDB, OP_LDI: begin
        dec_ctrl[B_AMUX +: 2] = 2'b01;
        dec_ctrl[B_MRD]   = 1'b1;
        dec_ctrl[B_MBYTE] = (op == OP_LDB);
        dec_ctrl[B_MIND]  = (op == OP_LDI);
        dec_ctrl[B_RSEL]  = 1'b1;
        dec_ctrl[B_CC]    = 1'b1;
        dec_ctrl[B_LDREG] = 1'b1;
        use_sr1 = (op != OP_LDI);
      end
      OP_STR, OP_STB, OP_STI: begin
        dec_ctrl[B_STM]   = 1'b1;
        dec_ctrl[B_AMUX +: 2] = 2'b01;
        dec_ctrl[B_MWR]   = 1'b1;
        dec_ctrl[B_MBYTE] = (op == OP_STB);
        dec_ctrl[B_MIND]  = (op == OP_STI);
        use_sr1 = (op != OP_STI);
        use_sd  = 1'b1;
      end
      OP_LEA: begin
        dec_ctrl[B_ALUOP +: 3] = AL_PASS;
        dec_ctrl[B_CC]    = 1'b1;
        dec_ctrl[B_LDREG] = 1'b1;
      end
      OP_BR: dec_ctrl[B_BR] = 1'b1;
      OP_JMP: begin
        dec_ctrl[B_JMP] = 1'b1;
        use_sr1 = 1'b1;
      end
      OP_JSR, OP_TRAP: begin
        dec_ctrl[B_JMP]   = 1'b1;
        dec_ctrl[B_PC2R]  = 1'b1;
        dec_ctrl[B_DMUX]  = 1'b1;
        dec_ctrl[B_LDREG] = 1'b1;
      end
      OP_RTI: dec_rti = 1'b1;
    endcase
  end

  assign src_hit = (use_sr1 && id_sr1 == ex_dest_q)
                || (use_sr2 && id_sr2 == ex_dest_q)
                || (use_sd  && id_dr  == ex_dest_q);

  assign load_use = (LOAD_USE_CHECK != 0) && id_valid
                 && ex_valid_q && ex_ctrl_q[B_MRD] && src_hit;

  assign mem_op    = mem_valid_q && (mem_ctrl_q[B_MRD] || mem_ctrl_q[B_MWR]);
  assign mem_final = (mst_q == M_FINAL)
                  || (mst_q == M_IDLE && !mem_ctrl_q[B_MIND]);
  assign mem_busy  = mem_op && !(mem_final && mem_resp);

  assign id_ready  = id_valid && !flush && !mem_busy && !load_use;
  assign take      = id_ready && !dec_rti;
  assign illegal_d = id_ready && dec_rti;

  // EX next state: flush kills, stall holds, otherwise accept or bubble
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_ctrl_d  = ex_ctrl_q;
    ex_dest_d  = ex_dest_q;
    if (flush) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      ex_dest_d  = '0;
    end else if (!mem_busy) begin
      ex_valid_d = take;
      ex_ctrl_d  = take ? dec_ctrl : '0;
      ex_dest_d  = take ? id_dr : '0;
    end
  end

  // EX stage register
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_dest_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_dest_q  <= ex_dest_d;
    end
  end

  // MEM holds while busy and WB takes a bubble; otherwise shift forward
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid_q <= 1'b0;
      mem_ctrl_q  <= '0;
      wb_valid_q  <= 1'b0;
      wb_ctrl_q   <= '0;
    end else if (mem_busy) begin
      wb_valid_q  <= 1'b0;
      wb_ctrl_q   <= '0;
    end else begin
      mem_valid_q <= ex_valid_q;
      mem_ctrl_q  <= ex_ctrl_q;
      wb_valid_q  <= mem_valid_q;
      wb_ctrl_q   <= mem_ctrl_q;
    end
  end

  // One-cycle pulse when an RTI is consumed and dropped at ID
  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  // Indirect access sequencer: pointer read, then the real access
  always_ff @(posedge clk) begin
    if (rst) begin
      mst_q   <= M_IDLE;
      phase_q <= 1'b0;
    end else if (!mem_busy) begin
      if (ex_ctrl_q[B_MIND]) begin
        mst_q   <= M_IND;
        phase_q <= 1'b1;
      end else begin
        mst_q   <= M_IDLE;
        phase_q <= 1'b0;
      end
    end else if (mst_q == M_IND && mem_resp) begin
      mst_q   <= M_FINAL;
      phase_q <= 1'b0;
    end
  end

  assign ex_ctrl            = ex_ctrl_q;
  assign mem_ctrl           = mem_ctrl_q;
  assign wb_ctrl            = wb_ctrl_q;
  assign ex_valid           = ex_valid_q;
  assign mem_valid          = mem_valid_q;
  assign wb_valid           = wb_valid_q;
  assign mem_indirect_phase = phase_q;
  assign illegal            = illegal_q;

`ifdef CTRL_PERF_CNT_EN
  logic [15:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;
  logic bubble_ins;

  assign bubble_ins = load_use && !flush && !mem_busy;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (mem_busy && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (bubble_ins && bubble_cnt_q != 16'hFFFF)
        bubble_cnt_q <= bubble_cnt_q + 16'd1;
      if (flush && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign perf_stall  = stall_cnt_q;
  assign perf_bubble = bubble_cnt_q;
  assign perf_flush  = flush_cnt_q;
`else
  assign perf_stall  = '0;
  assign perf_bubble = '0;
  assign perf_flush  = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: instruction-level pipeline model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ctrl_pipeline;

`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [15:0] id_ir = 16'h0;
  logic        flush = 1'b0;
  logic        mem_resp = 1'b0;
  logic        id_ready;
  logic [16:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic        ex_valid, mem_valid, wb_valid;
  logic        mem_indirect_phase, illegal;
  logic [15:0] perf_stall, perf_bubble, perf_flush;

  ctrl_pipeline #(
    .INSTR_W(16),
    .REG_IDX_W(3),
    .LOAD_USE_CHECK(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id_valid(id_valid),
    .id_ir(id_ir),
    .id_ready(id_ready),
    .flush(flush),
    .mem_resp(mem_resp),
    .ex_ctrl(ex_ctrl),
    .mem_ctrl(mem_ctrl),
    .wb_ctrl(wb_ctrl),
    .ex_valid(ex_valid),
    .mem_valid(mem_valid),
    .wb_valid(wb_valid),
    .mem_indirect_phase(mem_indirect_phase),
    .illegal(illegal),
    .perf_stall(perf_stall),
    .perf_bubble(perf_bubble),
    .perf_flush(perf_flush)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected control word per instruction, as literal words.
  function automatic logic [16:0] m_ctrl(input logic [15:0] ir);
    logic [16:0] w;
    w = '0;
    case (ir[15:12])
      4'h0: w = 17'h04000;
      4'h1: w = ir[5] ? 17'h02804 : 17'h02800;
      4'h2: w = 17'h02D42;
      4'h3: w = 17'h00183;
      4'h4: w = 17'h1B000;
      4'h5: w = ir[5] ? 17'h0280C : 17'h02808;
      4'h6: w = 17'h02C42;
      4'h7: w = 17'h00083;
      4'h8: w = 17'h00000;
      4'h9: w = ir[5] ? 17'h02814 : 17'h02810;
      4'hA: w = 17'h02E42;
      4'hB: w = 17'h00283;
      4'hC: w = 17'h08000;
      4'hD: begin
        if (ir[5:4] == 2'b01) w = 17'h0282E;
        else if (ir[5:4] == 2'b11) w = 17'h02836;
        else w = 17'h02826;
      end
      4'hE: w = 17'h02818;
      default: w = 17'h1B000;
    endcase
    return w;
  endfunction

  function automatic bit m_reads(input logic [15:0] ir, input logic [2:0] r);
    logic [3:0] o;
    bit a, b, c;
    o = ir[15:12];
    a = (o inside {4'h1, 4'h5, 4'h9, 4'hD, 4'h6, 4'h2, 4'h7, 4'h3, 4'hC})
        && ir[8:6] == r;
    b = (o inside {4'h1, 4'h5}) && !ir[5] && ir[2:0] == r;
    c = (o inside {4'h7, 4'h3, 4'hB}) && ir[11:9] == r;
    return a || b || c;
  endfunction

  // Instruction-level model: each slot holds an instruction word, MEM
  // counts completed accesses against the number the op needs.
  bit          started = 1'b0;
  logic        mx_v = 1'b0, mm_v = 1'b0, mw_v = 1'b0, mill = 1'b0;
  logic [15:0] mx_ir = 16'h0, mm_ir = 16'h0, mw_ir = 16'h0;
  int          mm_acc = 0;
  int          c_stall = 0, c_bub = 0, c_fl = 0;

  function automatic bit f_busy();
    logic [16:0] w;
    int need;
    w = m_ctrl(mm_ir);
    need = w[9] ? 2 : 1;
    return mm_v && (w[6] || w[7]) && !(mem_resp && mm_acc == need - 1);
  endfunction

  function automatic bit f_haz();
    logic [16:0] w;
    w = m_ctrl(mx_ir);
    return id_valid && mx_v && w[6] && m_reads(id_ir, mx_ir[11:9]);
  endfunction

  always @(posedge clk) begin : model
    bit b, h, nil;
    if (rst) begin
      started = 1'b1;
      mx_v = 0; mm_v = 0; mw_v = 0; mill = 0;
      mx_ir = 0; mm_ir = 0; mw_ir = 0;
      mm_acc = 0; c_stall = 0; c_bub = 0; c_fl = 0;
    end else begin
      b = f_busy();
      h = f_haz();
      nil = id_valid && id_ir[15:12] == 4'h8 && !flush && !b;
      if (b && c_stall < 65535) c_stall++;
      if (flush && c_fl < 65535) c_fl++;
      if (h && !flush && !b && c_bub < 65535) c_bub++;
      if (b) begin
        if (mem_resp) mm_acc++;
        mw_v = 0;
        mw_ir = 0;
      end else begin
        mw_v = mm_v; mw_ir = mm_ir;
        mm_v = mx_v; mm_ir = mx_ir;
        mm_acc = 0;
      end
      if (flush) begin
        mx_v = 0; mx_ir = 0;
      end else if (!b) begin
        if (id_valid && !h && id_ir[15:12] != 4'h8) begin
          mx_v = 1; mx_ir = id_ir;
        end else begin
          mx_v = 0; mx_ir = 0;
        end
      end
      mill = nil;
    end
  end

  always @(negedge clk) begin : compare
    logic [16:0] mw;
    if (started) begin
      mw = m_ctrl(mm_ir);
      chk("ex_valid", 32'(ex_valid), 32'(mx_v));
      chk("ex_ctrl", 32'(ex_ctrl), mx_v ? 32'(m_ctrl(mx_ir)) : 32'd0);
      chk("mem_valid", 32'(mem_valid), 32'(mm_v));
      chk("mem_ctrl", 32'(mem_ctrl), mm_v ? 32'(mw) : 32'd0);
      chk("wb_valid", 32'(wb_valid), 32'(mw_v));
      chk("wb_ctrl", 32'(wb_ctrl), mw_v ? 32'(m_ctrl(mw_ir)) : 32'd0);
      chk("mem_phase", 32'(mem_indirect_phase),
          32'(mm_v && mw[9] && mm_acc == 0));
      chk("illegal", 32'(illegal), 32'(mill));
      chk("id_ready", 32'(id_ready),
          32'(id_valid && !flush && !f_busy() && !f_haz()));
      chk("perf_stall", 32'(perf_stall), PERF ? 32'(c_stall) : 32'd0);
      chk("perf_bubble", 32'(perf_bubble), PERF ? 32'(c_bub) : 32'd0);
      chk("perf_flush", 32'(perf_flush), PERF ? 32'(c_fl) : 32'd0);
    end
  end

  task automatic cyc(input logic v, input logic [15:0] ir,
                     input logic fl, input logic rsp);
    @(posedge clk);
    #1;
    id_valid = v;
    id_ir    = ir;
    flush    = fl;
    mem_resp = rsp;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] pats [2];
    pats[0] = 16'h00E5;
    pats[1] = 16'h0010;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_wb_ctrl", 32'(wb_ctrl), 32'd0);
    chk("rst_phase", 32'(mem_indirect_phase), 32'd0);
    chk("rst_perf_stall", 32'(perf_stall), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ADD R1,R2,R3 travels ID->WB in three cycles
    cyc(1, 16'h1283, 0, 0);
    chk("t1_id_ready", 32'(id_ready), 32'd1);
    cyc(0, 16'h0, 0, 0);
    chk("t1_ex_ctrl", 32'(ex_ctrl), 32'h2800);
    chk("t1_ex_alumux", 32'(ex_ctrl[2:1]), 32'd0);
    cyc(0, 16'h0, 0, 0);
    chk("t1_mem_valid", 32'(mem_valid), 32'd1);
    cyc(0, 16'h0, 0, 0);
    chk("t1_wb_valid", 32'(wb_valid), 32'd1);
    chk("t1_wb_ctrl", 32'(wb_ctrl), 32'h2800);
    cyc(0, 16'h0, 0, 0);
    chk("t1_wb_gone", 32'(wb_valid), 32'd0);

    // LDR R1 then ADD R2,R1,R1: one load-use bubble
    cyc(1, 16'h6280, 0, 1);
    chk("t2_ldr_ready", 32'(id_ready), 32'd1);
    cyc(1, 16'h1441, 0, 1);
    chk("t2_hazard_ready", 32'(id_ready), 32'd0);
    cyc(1, 16'h1441, 0, 1);
    chk("t2_bubble", 32'(ex_valid), 32'd0);
    chk("t2_mem_ldr", 32'(mem_ctrl), 32'h2C42);
    chk("t2_retry_ready", 32'(id_ready), 32'd1);
    cyc(0, 16'h0, 0, 1);
    chk("t2_ex_add", 32'(ex_ctrl), 32'h2800);
    chk("t2_wb_ldr", 32'(wb_ctrl), 32'h2C42);
    chk("t2_perf_bubble", 32'(perf_bubble), PERF ? 32'd1 : 32'd0);
    cyc(0, 16'h0, 0, 0);
    cyc(0, 16'h0, 0, 0);

    // LDI with each response two cycles late
    cyc(1, 16'hA280, 0, 0);
    cyc(0, 16'h0, 0, 0);
    cyc(0, 16'h0, 0, 0);
    chk("t3_phase_a", 32'(mem_indirect_phase), 32'd1);
    cyc(0, 16'h0, 0, 0);
    chk("t3_phase_b", 32'(mem_indirect_phase), 32'd1);
    cyc(0, 16'h0, 0, 1);
    chk("t3_phase_c", 32'(mem_indirect_phase), 32'd1);
    cyc(0, 16'h0, 0, 0);
    chk("t3_phase_off", 32'(mem_indirect_phase), 32'd0);
    chk("t3_mem_held", 32'(mem_valid), 32'd1);
    cyc(0, 16'h0, 0, 0);
    cyc(0, 16'h0, 0, 1);
    chk("t3_wb_early", 32'(wb_valid), 32'd0);
    cyc(0, 16'h0, 0, 0);
    chk("t3_wb_valid", 32'(wb_valid), 32'd1);
    chk("t3_wb_ctrl", 32'(wb_ctrl), 32'h2E42);
    chk("t3_perf_stall", 32'(perf_stall), PERF ? 32'd5 : 32'd0);

    // Flush while STR waits in MEM
    cyc(1, 16'h7280, 0, 0);
    cyc(1, 16'h1283, 0, 0);
    cyc(1, 16'h5283, 0, 0);
    chk("t4_stall_ready", 32'(id_ready), 32'd0);
    cyc(1, 16'h5283, 1, 0);
    chk("t4_flush_ready", 32'(id_ready), 32'd0);
    cyc(1, 16'h5283, 0, 0);
    chk("t4_ex_killed", 32'(ex_valid), 32'd0);
    chk("t4_mem_str", 32'(mem_ctrl), 32'h0083);
    cyc(1, 16'h5283, 0, 1);
    chk("t4_resume_ready", 32'(id_ready), 32'd1);
    cyc(0, 16'h0, 0, 0);
    chk("t4_wb_str", 32'(wb_ctrl), 32'h0083);
    chk("t4_ex_and", 32'(ex_ctrl), 32'h2808);
    chk("t4_perf_flush", 32'(perf_flush), PERF ? 32'd1 : 32'd0);
    chk("t4_perf_stall", 32'(perf_stall), PERF ? 32'd8 : 32'd0);
    cyc(0, 16'h0, 0, 0);
    cyc(0, 16'h0, 0, 0);

    // RTI is dropped with a one-cycle illegal pulse
    cyc(1, 16'h8000, 0, 0);
    chk("t5_ready", 32'(id_ready), 32'd1);
    cyc(0, 16'h0, 0, 0);
    chk("t5_illegal", 32'(illegal), 32'd1);
    chk("t5_ex_bubble", 32'(ex_valid), 32'd0);
    cyc(0, 16'h0, 0, 0);
    chk("t5_illegal_off", 32'(illegal), 32'd0);
    cyc(0, 16'h0, 0, 0);
    chk("t5_no_wb", 32'(wb_valid), 32'd0);

    // Every opcode back to back, memory always answering
    for (int p = 0; p < 2; p++) begin
      for (int o = 0; o < 16; o++) begin
        cyc(1, {4'(o), pats[p][11:0]}, 0, 1);
      end
    end
    repeat (5) cyc(0, 16'h0, 0, 1);

    // Reset while STI is in its pointer access
    cyc(1, 16'hB280, 0, 0);
    cyc(1, 16'h1283, 0, 0);
    cyc(0, 16'h0, 0, 0);
    chk("t6_phase", 32'(mem_indirect_phase), 32'd1);
    chk("t6_ex_valid", 32'(ex_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_ex_valid_rst", 32'(ex_valid), 32'd0);
    chk("t6_mem_valid_rst", 32'(mem_valid), 32'd0);
    chk("t6_wb_valid_rst", 32'(wb_valid), 32'd0);
    chk("t6_mem_ctrl_rst", 32'(mem_ctrl), 32'd0);
    chk("t6_ex_ctrl_rst", 32'(ex_ctrl), 32'd0);
    chk("t6_phase_rst", 32'(mem_indirect_phase), 32'd0);
    chk("t6_perf_rst", 32'(perf_stall), 32'd0);
    cyc(0, 16'h0, 0, 1);
    cyc(0, 16'h0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
